instr_sequencer: RTL

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/instr_sequencer_pkg.sv | 29 ++
 rtl/instr_seq_retire_cnt.sv | 23 ++
 rtl/instr_sequencer.sv | 131 +++++++++++++
 3 files changed

// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: FSM state encodings,
// the opcodes that steer the sequence, and the PC source select codes.
package instr_sequencer_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  // Opcodes with dedicated sequencing; every other opcode is an ALU op.
  localparam logic [5:0] JUMP = 6'h02;
  localparam logic [5:0] BEQ  = 6'h04;
  localparam logic [5:0] LDW  = 6'h23;
  localparam logic [5:0] SDW  = 6'h2B;

  // PC source select.
  localparam logic [1:0] PC_SEL_SEQ    = 2'b00;  // PC + 4
  localparam logic [1:0] PC_SEL_BRANCH = 2'b01;  // branch target
  localparam logic [1:0] PC_SEL_JUMP   = 2'b10;  // jump target

  // True for opcodes that need a data-memory access.
  function automatic logic is_mem_op(input logic [5:0] op);
    return (op == LDW) || (op == SDW);
  endfunction

endpackage

// File: rtl/instr_seq_retire_cnt.sv
// Retired-instruction counter: counts cycles in which the PC is updated,
// which happens exactly once per instruction. Wraps naturally at 2^32.
module instr_seq_retire_cnt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_inc,
  output logic [31:0] o_count
);

  logic [31:0] r_count;

  // Count one per retiring instruction; wrap from all-ones to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + 32'd1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: FETCH -> DECODE -> EXEC -> [MEM] -> [WB].
// Outputs are decoded from the current state, the opcode latched in DECODE
// and the ALU zero flag, so the raw opcode input is ignored after DECODE.
// Optional feature: define INSTR_SEQ_RETIRE_CNT_EN to add the retire_cnt
// output, driven by the instr_seq_retire_cnt sub-module.
module instr_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  opcode,
  input  logic [4:0]  rwd,
  input  logic        zero,
  output logic        imem_req,
  input  logic        imem_ack,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        ir_load,
  output logic        pc_load,
  output logic [1:0]  pc_sel,
  output logic        alu_en,
  output logic        reg_we,
  output logic [2:0]  state
`ifdef INSTR_SEQ_RETIRE_CNT_EN
  ,
  output logic [31:0] retire_cnt
`endif
);

  import instr_sequencer_pkg::*;

  state_t     r_state;
  state_t     w_state_next;
  logic [5:0] r_opcode;
  // Holds imem_req low during reset and until the first edge after release.
  logic       r_run;

  // State register, opcode latch (captured in DECODE) and run-enable flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= FETCH;
      r_opcode <= '0;
      r_run    <= 1'b0;
    end else begin
      r_run   <= 1'b1;
      r_state <= w_state_next;
      if (r_state == DECODE) begin
        r_opcode <= opcode;
      end
    end
  end

  // Next-state and output decode; everything defaults to inactive.
  always_comb begin
    w_state_next = r_state;
    imem_req     = 1'b0;
    ir_load      = 1'b0;
    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    pc_load      = 1'b0;
    pc_sel       = PC_SEL_SEQ;
    alu_en       = 1'b0;
    reg_we       = 1'b0;
    case (r_state)
      FETCH: begin
        if (r_run) begin
          imem_req = 1'b1;
          if (imem_ack) begin
            ir_load      = 1'b1;
            w_state_next = DECODE;
          end
        end
      end
      DECODE: begin
        w_state_next = EXEC;
      end
      EXEC: begin
        alu_en = 1'b1;
        if (r_opcode == JUMP) begin
          pc_load      = 1'b1;
          pc_sel       = PC_SEL_JUMP;
          w_state_next = FETCH;
        end else if (r_opcode == BEQ) begin
          pc_load      = 1'b1;
          pc_sel       = zero ? PC_SEL_BRANCH : PC_SEL_SEQ;
          w_state_next = FETCH;
        end else if (is_mem_op(r_opcode)) begin
          w_state_next = MEM;
        end else begin
          w_state_next = WB;
        end
      end
      MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (r_opcode == SDW);
        if (dmem_ack) begin
          if (r_opcode == SDW) begin
            // A store has nothing to write back: it retires here.
            pc_load      = 1'b1;
            pc_sel       = PC_SEL_SEQ;
            w_state_next = FETCH;
          end else begin
            w_state_next = WB;
          end
        end
      end
      WB: begin
        reg_we       = (rwd != 5'd0);
        pc_load      = 1'b1;
        pc_sel       = PC_SEL_SEQ;
        w_state_next = FETCH;
      end
      default: begin
        w_state_next = FETCH;
      end
    endcase
  end

  assign state = r_state;

`ifdef INSTR_SEQ_RETIRE_CNT_EN
  instr_seq_retire_cnt u_retire_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (pc_load),
    .o_count (retire_cnt)
  );
`else
  // No retire counter in this build.
`endif

endmodule
